rx_lane_sync_ctrl: RTL
======================

Name: rx_lane_sync_ctrl

Overview:
Per-lane receive synchronization controller on the clk_f side of the phy_rx path. It consumes the byte stream and valid bit produced by the serial-to-parallel converter, acquires lock on the 0xBC comma/idle symbol, and forwards only payload bytes while locked. It detects loss of lock, runs an acquisition watchdog, and keeps saturating status counters for the link-layer logic above it.

Parameters:
COMMA, 8'hBC, comma/idle symbol value
LOCK_CNT, 4, consecutive valid COMMA bytes required to declare lock (range 1..15)
LOSS_CNT, 3, consecutive invalid cycles in LOCKED that force loss of lock (range 1..15)
TIMEOUT, 1024, SEEK cycles allowed before the watchdog fires (range 2..65535)

Ports:
clk_f  input  1  lane byte clock; all logic is on its rising edge
reset_L  input  1  asynchronous, active-low reset
enable  input  1  lane enable; 0 forces IDLE
data_in  input  8  parallel byte from the serial-to-parallel converter
valid_in  input  1  data_in qualifier
data_out  output  8  forwarded payload byte
valid_out  output  1  data_out qualifier
locked  output  1  1 while state is LOCKED
state  output  2  encoded FSM state, for debug/status
timeout  output  1  one-cycle pulse when the watchdog fires
loss_cnt  output  8  saturating count of lock losses
drop_cnt  output  8  saturating count of invalid cycles seen while LOCKED

Behaviour:
- Reset (reset_L=0, asynchronous): state=IDLE. data_out=0, valid_out=0, locked=0, timeout=0, loss_cnt=0, drop_cnt=0. Internal comma, bad and watchdog counters are set to 0.
- All outputs are registered. Payload latency is exactly one clk_f cycle, data_in to data_out.
- State encoding: IDLE=0, SEEK=1, LOCKED=2. Value 3 is illegal and returns to IDLE on the next edge.
- enable=0 in any state: go to IDLE next cycle and clear the comma, bad and watchdog counters. loss_cnt and drop_cnt are held.
- IDLE: when enable=1, go to SEEK.
- SEEK:
  - Watchdog increments every cycle.
  - If valid_in=1 and data_in==COMMA: the comma counter increments.
  - Any other cycle (valid_in=0, or a non-COMMA byte) clears the comma counter.
  - When the comma counter would reach LOCK_CNT: go to LOCKED. Clear the comma counter and the watchdog.
  - When the watchdog reaches TIMEOUT-1 without lock: pulse timeout for one cycle, clear the watchdog and comma counter, and stay in SEEK.
  - If lock and timeout occur on the same cycle, lock wins and timeout stays 0.
- LOCKED:
  - valid_in=1 and data_in!=COMMA: forward the byte (data_out<=data_in, valid_out<=1) and clear the bad counter.
  - valid_in=1 and data_in==COMMA: idle symbol. Not forwarded (valid_out<=0), bad counter cleared, data_out holds its value.
  - valid_in=0: valid_out<=0, the bad counter increments, and drop_cnt increments (saturating at 255).
  - When the bad counter would reach LOSS_CNT: go to SEEK, increment loss_cnt (saturating at 255), clear the bad counter, and drop locked on that same edge.
- valid_out is 0 in every state except LOCKED. data_out holds its last value when valid_out=0.
- locked = (state==LOCKED), registered together with state.
- Counter widths:
  - Comma and bad counters: 4 bits.
  - Watchdog: 16 bits.
  - Status counters: 8 bits, saturating, never wrap.
- Reset asserted mid-operation clears everything immediately, including loss_cnt and drop_cnt.

Decomposition:
- Shared package phy_rx_pkg holds:
  - the state encoding constants (ST_IDLE, ST_SEEK, ST_LOCKED);
  - the COMMA default 8'hBC, shared with the serial-to-parallel converter and the transmit-side idle inserter.
- One natural sub-module, sat_counter (parameterized WIDTH, inc and clr inputs, saturating). It is instantiated twice, for loss_cnt and drop_cnt.
- The FSM and its internal counters stay in the top module.

Test Plan:
1. Reset then enable=1, drive valid 0xBC for 4 cycles -> state goes 0→1, locked=1 on the edge after the 4th BC; valid_out stays 0 throughout.
2. Locked, drive valid bytes 0x12, 0xBC, 0x34 -> one cycle later valid_out=1 with 0x12, then valid_out=0, then valid_out=1 with 0x34.
3. Locked, drive valid_in=0 for 3 cycles -> drop_cnt=3, state=SEEK and locked=0 after the 3rd cycle, loss_cnt=1. With 2 invalid cycles, then a valid byte, then 2 more invalid cycles, lock must hold.
4. TIMEOUT=16, SEEK with only 0x00 bytes -> timeout pulses for one cycle every 16 cycles and the state stays SEEK. Three BCs followed by 0x00 resets acquisition (no lock).
5. Locked, deassert enable for 1 cycle -> state=IDLE, then SEEK; a full LOCK_CNT of commas is required again; loss_cnt is unchanged.
6. Run 300 lock-loss events -> loss_cnt saturates at 255. Assert reset_L=0 asynchronously between clock edges -> all outputs are 0 before the next clk_f edge.

Source files
------------

// File: rtl/phy_rx_pkg.sv
// Shared definitions for the phy_rx receive path: FSM state encoding and the
// comma/idle symbol used by the deserializer, lane sync and the TX idle inserter.
package phy_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEEK   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic [7:0] COMMA_DEFAULT = 8'hBC;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; used for the lane status counters.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_f,
  input  logic             reset_L,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of process order.
  always_ff @(posedge clk_f or negedge reset_L) begin
    if (!reset_L) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/rx_lane_sync_ctrl.sv
// Per-lane receive sync: acquires lock on the comma symbol, forwards payload
// bytes while locked, detects loss of lock and runs an acquisition watchdog.
module rx_lane_sync_ctrl
  import phy_rx_pkg::*;
#(
  parameter logic [7:0] COMMA    = COMMA_DEFAULT,
  parameter int         LOCK_CNT = 4,
  parameter int         LOSS_CNT = 3,
  parameter int         TIMEOUT  = 1024
) (
  input  logic       clk_f,
  input  logic       reset_L,
  input  logic       enable,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       locked,
  output logic [1:0] state,
  output logic       timeout,
  output logic [7:0] loss_cnt,
  output logic [7:0] drop_cnt
);

  localparam logic [3:0]  LOCK_TGT = 4'(LOCK_CNT);
  localparam logic [3:0]  LOSS_TGT = 4'(LOSS_CNT);
  localparam logic [15:0] WD_LAST  = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [3:0]  comma_q, comma_d;
  logic [3:0]  bad_q, bad_d;
  logic [15:0] wd_q, wd_d;
  logic [7:0]  data_d;
  logic        valid_d;
  logic        timeout_d;
  logic        loss_inc;
  logic        drop_inc;
  logic        is_comma;

  assign is_comma = valid_in && (data_in == COMMA);
  assign state    = state_q;

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch. Counters default to cleared.
  always_comb begin
    state_d   = state_q;
    comma_d   = '0;
    bad_d     = '0;
    wd_d      = '0;
    data_d    = data_out;
    valid_d   = 1'b0;
    timeout_d = 1'b0;
    loss_inc  = 1'b0;
    drop_inc  = 1'b0;

    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_SEEK;

        ST_SEEK: begin
          // Lock is tested first so it wins over a watchdog expiry on the same cycle.
          if (is_comma && (comma_q + 4'd1 == LOCK_TGT)) begin
            state_d = ST_LOCKED;
          end else if (wd_q == WD_LAST) begin
            timeout_d = 1'b1;
          end else begin
            wd_d    = wd_q + 16'd1;
            comma_d = is_comma ? comma_q + 4'd1 : 4'd0;
          end
        end

        ST_LOCKED: begin
          if (valid_in) begin
            if (!is_comma) begin
              data_d  = data_in;
              valid_d = 1'b1;
            end
          end else begin
            drop_inc = 1'b1;
            if (bad_q + 4'd1 == LOSS_TGT) begin
              state_d  = ST_SEEK;
              loss_inc = 1'b1;
            end else begin
              bad_d = bad_q + 4'd1;
            end
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_f or negedge reset_L) begin
    if (!reset_L) begin
      state_q   <= ST_IDLE;
      comma_q   <= '0;
      bad_q     <= '0;
      wd_q      <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      timeout   <= 1'b0;
      locked    <= 1'b0;
    end else begin
      state_q   <= state_d;
      comma_q   <= comma_d;
      bad_q     <= bad_d;
      wd_q      <= wd_d;
      data_out  <= data_d;
      valid_out <= valid_d;
      timeout   <= timeout_d;
      locked    <= (state_d == ST_LOCKED);
    end
  end

  sat_counter #(.WIDTH(8)) u_loss_cnt (
    .clk_f   (clk_f),
    .reset_L (reset_L),
    .inc     (loss_inc),
    .clr     (1'b0),
    .count   (loss_cnt)
  );

  sat_counter #(.WIDTH(8)) u_drop_cnt (
    .clk_f   (clk_f),
    .reset_L (reset_L),
    .inc     (drop_inc),
    .clr     (1'b0),
    .count   (drop_cnt)
  );

endmodule
